mvu_csr_apb_master: RTL

- Upstream APB requester for the MVU CSR bank.
- Accepts CSR write commands (target MVU id, 12-bit CSR offset, 32-bit data) on a valid/ready interface and buffers them in a small FIFO.
- Replays each command as a standard two-phase APB write: SETUP, then ACCESS held until pready.
- Its APB outputs connect directly to the MVU APB slave port. Address layout is {mvu_id, csr[11:0]}, so bits [APB_ADDR_WIDTH-1:12] select the MVU.

---
 rtl/mvu_csr_apb_if.sv | 31 +++
 rtl/mvu_csr_apb_master.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mvu_csr_apb_if.sv
// Command-side valid/ready channel and APB write bus between the CSR
// requester (master modport) and its environment (slave modport).
interface mvu_csr_apb_if #(
  parameter int BMVUA          = 3,
  parameter int APB_ADDR_WIDTH = 15,
  parameter int APB_DATA_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [BMVUA-1:0]          cmd_mvu_id;
  logic [11:0]               cmd_csr;
  logic [APB_DATA_WIDTH-1:0] cmd_data;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  cmd_valid, cmd_mvu_id, cmd_csr, cmd_data, pready, pslverr,
    output cmd_ready, paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_mvu_id, cmd_csr, cmd_data, pready, pslverr,
    input  cmd_ready, paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/mvu_csr_apb_master.sv
// Buffers CSR write commands in a small FIFO and replays each one as a
// two-phase APB write towards the MVU CSR bank.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | bus quiet; launches SETUP as soon as the FIFO holds an entry
//   SETUP  | psel=1, penable=0 for exactly one cycle
//   ACCESS | psel=1, penable=1 until pready; pops head on completion
module mvu_csr_apb_master #(
  parameter int NMVU           = 8,
  parameter int BMVUA          = 3,
  parameter int APB_ADDR_WIDTH = 15,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int BERRCNT        = 8
) (
  input  logic               clk,
  input  logic               rst,
  mvu_csr_apb_if.master      bus,
  output logic               idle,
  output logic               err_sticky,
  output logic [BERRCNT-1:0] err_count,
  input  logic               err_clr
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;

  if (APB_ADDR_WIDTH != BMVUA + 12 || NMVU > (1 << BMVUA) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("mvu_csr_apb_master: inconsistent parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e                    state_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;

  logic [APB_ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [APB_DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]             rd_ptr_nxt;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                      err_sticky_q, err_sticky_d;
  logic [BERRCNT-1:0]        err_count_q, err_count_d;

  logic                      push, pop, more;
  logic [APB_ADDR_WIDTH-1:0] push_addr, head_addr, next_addr;
  logic [APB_DATA_WIDTH-1:0] head_data, next_data;

  assign bus.cmd_ready = !rst && (count_q < CNT_W'(FIFO_DEPTH));

  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign pop       = (state_q == S_ACCESS) && bus.pready;
  assign push_addr = {bus.cmd_mvu_id, bus.cmd_csr};

  assign rd_ptr_nxt = rd_ptr_q + PW'(1);
  assign head_addr  = addr_mem[rd_ptr_q];
  assign head_data  = data_mem[rd_ptr_q];

  // With a single entry being popped, the only successor is the command
  // being pushed this very cycle; it is not in the array yet, so bypass it.
  assign more      = (count_q > CNT_W'(1)) || push;
  assign next_addr = (count_q > CNT_W'(1)) ? addr_mem[rd_ptr_nxt] : push_addr;
  assign next_data = (count_q > CNT_W'(1)) ? data_mem[rd_ptr_nxt] : bus.cmd_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_nxt;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q  <= S_SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= 1'b1;
            paddr_q  <= head_addr;
            pwdata_q <= head_data;
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          if (bus.pready) begin
            penable_q <= 1'b0;
            if (more) begin
              state_q  <= S_SETUP;
              paddr_q  <= next_addr;
              pwdata_q <= next_data;
            end else begin
              state_q  <= S_IDLE;
              psel_q   <= 1'b0;
              pwrite_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          pwrite_q  <= 1'b0;
        end
      endcase
    end
  end

  // A clear that coincides with an error completion still records that error.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (pop && bus.pslverr) begin
      err_sticky_d = 1'b1;
      if (err_clr)              err_count_d = BERRCNT'(1);
      else if (!(&err_count_q)) err_count_d = err_count_q + BERRCNT'(1);
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;

  assign idle       = (count_q == '0) && (state_q == S_IDLE);
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule
